// File: rtl/dirty_byte_encoder.sv
// dirty_byte_encoder
//   Walks the dirty-byte mask of one cache line and serializes each dirty
//   byte with its encoded byte offset, lowest offset first, one byte per
//   out_valid/out_ready handshake. It sits between the cache data array and
//   the write-back path for partial-line write-backs.
//
//   Optional feature macro: DBE_ABORT_EN
//     When defined, an abort input is added. abort=1 in SEND drops the rest
//     of the line without a done pulse, and it takes priority over a transfer
//     in the same cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   load        in   capture load_mask/load_line (ignored while busy)
//   load_mask   in   dirty-byte mask, bit i = byte i dirty
//   load_line   in   line data, byte i = load_line[DATA_W*i +: DATA_W]
//   busy        out  high while serializing a line
//   out_valid   out  out_offset/out_byte/out_last are valid
//   out_ready   in   downstream accepts the current byte
//   abort       in   (DBE_ABORT_EN only) drop the remainder of the line
//   out_offset  out  offset of the lowest remaining dirty byte
//   out_byte    out  data byte at out_offset
//   out_last    out  current byte is the final dirty byte
//   done        out  one-cycle pulse once a line is fully serialized
module dirty_byte_encoder #(
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned OFF_W      = 4,
   parameter int unsigned DATA_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic [LINE_BYTES-1:0]        load_mask,
   input  logic [LINE_BYTES*DATA_W-1:0] load_line,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
`ifdef DBE_ABORT_EN
   input  logic                         abort,
`endif
   output logic [OFF_W-1:0]             out_offset,
   output logic [DATA_W-1:0]            out_byte,
   output logic                         out_last,
   output logic                         done
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                       state_q, state_d;
   logic [LINE_BYTES-1:0]        mask_q, mask_d;
   logic [LINE_BYTES*DATA_W-1:0] line_q, line_d;
   logic                         done_q, done_d;

   logic [OFF_W-1:0]             enc_off;
   logic                         single_bit;
   logic                         sending;
   logic                         abort_hit;

`ifdef DBE_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign sending = (state_q == SEND);

   // Priority encoder: first set bit scanning upward wins.
   always_comb begin
      logic found;
      enc_off = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
         if (mask_q[i] && !found) begin
            enc_off = OFF_W'(i);
            found   = 1'b1;
         end
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign single_bit = (mask_q != '0) &&
                       ((mask_q & (mask_q - LINE_BYTES'(1))) == '0);

   always_comb begin
      busy       = sending;
      out_valid  = sending;
      out_offset = '0;
      out_byte   = '0;
      out_last   = 1'b0;
      done       = done_q;
      if (sending) begin
         out_offset = enc_off;
         out_byte   = line_q[DATA_W*enc_off +: DATA_W];
         out_last   = single_bit;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      line_d  = line_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               if (load_mask != '0) begin
                  mask_d  = load_mask;
                  line_d  = load_line;
                  state_d = SEND;
               end else begin
                  // Nothing dirty: report completion without entering SEND.
                  done_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (abort_hit) begin
               mask_d  = '0;
               state_d = IDLE;
            end else if (out_ready) begin
               mask_d[enc_off] = 1'b0;
               if (single_bit) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         line_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_dirty_byte_encoder.sv
module tb_dirty_byte_encoder;

   logic         clk;
   logic         rst_n;
   logic         load;
   logic [15:0]  load_mask;
   logic [127:0] load_line;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
`ifdef DBE_ABORT_EN
   logic         abort;
`endif
   logic [3:0]   out_offset;
   logic [7:0]   out_byte;
   logic         out_last;
   logic         done;

   int total;
   int bad;

   // byte i = {i,i}: 00,11,22,...,FF
   localparam logic [127:0] LINE_IDX = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
   localparam logic [127:0] LINE_5A  = {16{8'h5A}};

   dirty_byte_encoder #(
      .LINE_BYTES(16),
      .OFF_W     (4),
      .DATA_W    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_mask (load_mask),
      .load_line (load_line),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef DBE_ABORT_EN
      .abort     (abort),
`endif
      .out_offset(out_offset),
      .out_byte  (out_byte),
      .out_last  (out_last),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [3:0] off,
                          input logic [7:0] b, input logic last, input logic dn);
      chk({tag, ".valid"},  32'(out_valid),  32'(v));
      chk({tag, ".busy"},   32'(busy),       32'(v));
      chk({tag, ".offset"}, 32'(out_offset), 32'(off));
      chk({tag, ".byte"},   32'(out_byte),   32'(b));
      chk({tag, ".last"},   32'(out_last),   32'(last));
      chk({tag, ".done"},   32'(done),       32'(dn));
   endtask

   initial begin
      logic [3:0] t3_off  [7];
      logic       t3_rdy  [7];
      logic       t3_last [7];
      logic [3:0] o;

      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      load      = 1'b0;
      load_mask = '0;
      load_line = '0;
      out_ready = 1'b0;
`ifdef DBE_ABORT_EN
      abort     = 1'b0;
`endif
      #2;
      chk_all("reset", 0, 4'h0, 8'h00, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("idle", 0, 4'h0, 8'h00, 0, 0);

      // 1: single dirty byte
      load = 1'b1; load_mask = 16'h0001; load_line = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
      out_ready = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk_all("t1_beat", 1, 4'h0, 8'hA5, 1, 0);
      @(negedge clk);
      chk_all("t1_done", 0, 4'h0, 8'h00, 0, 1);
      @(negedge clk);
      chk_all("t1_after", 0, 4'h0, 8'h00, 0, 0);

      // 2: sparse mask, full throughput
      load = 1'b1; load_mask = 16'h8421; load_line = LINE_IDX;
      @(negedge clk);
      load = 1'b0;
      chk_all("t2_b0", 1, 4'h0, 8'h00, 0, 0);
      @(negedge clk);
      chk_all("t2_b1", 1, 4'h5, 8'h55, 0, 0);
      @(negedge clk);
      chk_all("t2_b2", 1, 4'hA, 8'hAA, 0, 0);
      @(negedge clk);
      chk_all("t2_b3", 1, 4'hF, 8'hFF, 1, 0);
      @(negedge clk);
      chk_all("t2_done", 0, 4'h0, 8'h00, 0, 1);
      @(negedge clk);
      chk_all("t2_after", 0, 4'h0, 8'h00, 0, 0);

      // 3: backpressure; ready chosen per sample point for the next edge
      t3_off  = '{4'h4, 4'h5, 4'h5, 4'h5, 4'h6, 4'h7, 4'h7};
      t3_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      t3_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      load = 1'b1; load_mask = 16'h00F0; load_line = LINE_IDX;
      @(negedge clk);
      load = 1'b0;
      for (int c = 0; c < 7; c++) begin
         o = t3_off[c];
         chk_all($sformatf("t3_c%0d", c), 1, o, {o, o}, t3_last[c], 0);
         out_ready = t3_rdy[c];
         @(negedge clk);
      end
      chk_all("t3_done", 0, 4'h0, 8'h00, 0, 1);
      @(negedge clk);
      chk_all("t3_after", 0, 4'h0, 8'h00, 0, 0);

      // 4: empty mask
      load = 1'b1; load_mask = 16'h0000; load_line = LINE_IDX;
      @(negedge clk);
      load = 1'b0;
      chk_all("t4_done", 0, 4'h0, 8'h00, 0, 1);
      @(negedge clk);
      chk_all("t4_after", 0, 4'h0, 8'h00, 0, 0);

      // 5: full line, loads while busy are ignored
      load = 1'b1; load_mask = 16'hFFFF; load_line = LINE_IDX;
      @(negedge clk);
      load_mask = 16'h0001; load_line = LINE_5A;
      for (int i = 0; i < 16; i++) begin
         o = 4'(i);
         chk_all($sformatf("t5_b%0d", i), 1, o, {o, o}, (i == 15), 0);
         load = (i < 8);
         @(negedge clk);
      end
      chk_all("t5_done", 0, 4'h0, 8'h00, 0, 1);
      load = 1'b1; load_mask = 16'h00FF; load_line = LINE_5A;
      @(negedge clk);
      load = 1'b0;
      chk_all("t5_l2b0", 1, 4'h0, 8'h5A, 0, 0);
      @(negedge clk);
      chk_all("t5_l2b1", 1, 4'h1, 8'h5A, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk_all("t5_rst", 0, 4'h0, 8'h00, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("t5_post0", 0, 4'h0, 8'h00, 0, 0);
      @(negedge clk);
      chk_all("t5_post1", 0, 4'h0, 8'h00, 0, 0);

`ifdef DBE_ABORT_EN
      // 6: abort on the second handshake
      load = 1'b1; load_mask = 16'h0F00; load_line = LINE_IDX;
      @(negedge clk);
      load = 1'b0;
      chk_all("t6_b0", 1, 4'h8, 8'h88, 0, 0);
      @(negedge clk);
      chk_all("t6_b1", 1, 4'h9, 8'h99, 0, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_all("t6_abort", 0, 4'h0, 8'h00, 0, 0);
      load = 1'b1; load_mask = 16'h0002; load_line = LINE_IDX;
      @(negedge clk);
      load = 1'b0;
      chk_all("t6_nb0", 1, 4'h1, 8'h11, 1, 0);
      @(negedge clk);
      chk_all("t6_done", 0, 4'h0, 8'h00, 0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
